// File: rtl/me_search_sequencer.sv
// rtl/me_search_sequencer.sv - full-search block-matching motion estimator control unit
module me_search_sequencer #(
    parameter int ROM_LAT = 1,
    parameter int PE_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        completed,
    output logic        busy,
    output logic [7:0]  AddressR,
    output logic [9:0]  AddressS1,
    output logic [9:0]  AddressS2,
    output logic        pe_valid,
    output logic        pe_clear,
    output logic [15:0] pe_sel,
    output logic        cmp_clear,
    output logic        cmp_load,
    output logic [3:0]  cmp_vy
);
    localparam int L = ROM_LAT + PE_LAT;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [4:0]  row_d;
    logic [9:0]  s1_d;

    logic [17:0] pe_pipe_q  [ROM_LAT];
    logic [4:0]  cmp_pipe_q [L];
    logic        issue;
    logic [17:0] pe_in;
    logic [4:0]  cmp_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 12'd0;
                if (start) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == 12'hFFF) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == 12'(L - 1)) begin
                    state_d = DONE;
                    cnt_d   = 12'd0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: begin
                cnt_d = 12'd0;
                if (!start) state_d = IDLE;
            end
        endcase
    end

    // Addresses are registered from the next count so issue n is visible while cnt_q == n.
    assign row_d = {1'b0, cnt_d[11:8]} + {1'b0, cnt_d[7:4]};
    assign s1_d  = {row_d, 5'b0} - {5'b0, row_d} + {6'b0, cnt_d[3:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 12'd0;
            busy      <= 1'b0;
            completed <= 1'b0;
            cmp_clear <= 1'b0;
            AddressR  <= 8'd0;
            AddressS1 <= 10'd0;
            AddressS2 <= 10'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy      <= (state_d == RUN) || (state_d == DRAIN);
            completed <= (state_d == DONE);
            cmp_clear <= (state_q == IDLE) && start;
            if (state_d == RUN) begin
                AddressR  <= cnt_d[7:0];
                AddressS1 <= s1_d;
                AddressS2 <= s1_d + 10'd15;
            end else begin
                AddressR  <= 8'd0;
                AddressS1 <= 10'd0;
                AddressS2 <= 10'd0;
            end
        end
    end

    // Strobes for the issue currently on the address bus, fed into the latency pipes.
    assign issue  = (state_q == RUN);
    assign pe_in  = {issue,
                     issue && (cnt_q[7:0] == 8'h00),
                     issue ? (16'hFFFF << ({1'b0, cnt_q[3:0]} + 5'd1)) : 16'h0000};
    assign cmp_in = (issue && (cnt_q[7:0] == 8'hFF)) ? {1'b1, cnt_q[11:8]} : 5'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < ROM_LAT; k++) pe_pipe_q[k] <= 18'd0;
            for (int k = 0; k < L; k++)       cmp_pipe_q[k] <= 5'd0;
        end else begin
            pe_pipe_q[0]  <= pe_in;
            cmp_pipe_q[0] <= cmp_in;
            for (int k = 1; k < ROM_LAT; k++) pe_pipe_q[k] <= pe_pipe_q[k-1];
            for (int k = 1; k < L; k++)       cmp_pipe_q[k] <= cmp_pipe_q[k-1];
        end
    end

    assign pe_valid = pe_pipe_q[ROM_LAT-1][17];
    assign pe_clear = pe_pipe_q[ROM_LAT-1][16];
    assign pe_sel   = pe_pipe_q[ROM_LAT-1][15:0];
    assign cmp_load = cmp_pipe_q[L-1][4];
    assign cmp_vy   = cmp_pipe_q[L-1][3:0];
endmodule

// File: tb/tb_me_search_sequencer.sv
// tb/tb_me_search_sequencer.sv - bench for me_search_sequencer at two latency settings
module tb_me_search_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic        comp_a, busy_a, pv_a, pc_a, cclr_a, cload_a;
    logic [7:0]  r_a;
    logic [9:0]  s1_a, s2_a;
    logic [15:0] sel_a;
    logic [3:0]  vy_a;
    logic        comp_b, busy_b, pv_b, pc_b, cclr_b, cload_b;
    logic [7:0]  r_b;
    logic [9:0]  s1_b, s2_b;
    logic [15:0] sel_b;
    logic [3:0]  vy_b;

    me_search_sequencer #(.ROM_LAT(1), .PE_LAT(1)) dut_a (
        .clock(clock), .reset(reset), .start(start), .completed(comp_a), .busy(busy_a),
        .AddressR(r_a), .AddressS1(s1_a), .AddressS2(s2_a), .pe_valid(pv_a), .pe_clear(pc_a),
        .pe_sel(sel_a), .cmp_clear(cclr_a), .cmp_load(cload_a), .cmp_vy(vy_a));

    me_search_sequencer #(.ROM_LAT(2), .PE_LAT(3)) dut_b (
        .clock(clock), .reset(reset), .start(start), .completed(comp_b), .busy(busy_b),
        .AddressR(r_b), .AddressS1(s1_b), .AddressS2(s2_b), .pe_valid(pv_b), .pe_clear(pc_b),
        .pe_sel(sel_b), .cmp_clear(cclr_b), .cmp_load(cload_b), .cmp_vy(vy_b));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; int vy; } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    typedef struct {
        int          off;
        logic [7:0]  r;
        logic [9:0]  s1, s2;
        logic        pv, pc;
        logic [15:0] sel;
        logic        busy, comp, cclr, cload;
        logic [3:0]  vy;
    } vec_t;
    vec_t tab[12];

    int tests = 0;
    int failed = 0;
    int t0 = 0;
    int clr_a, clr_b, pcn_a, pcn_b, pvf_a, pvf_b, rise_a, rise_b, pc_bad;
    logic prev_a = 1'b0, prev_b = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (cycle offset %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Every wait goes through here so the scoreboard sees each cycle.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (cload_a === 1'b1) begin
            if (qa.size() == 0) chk("a_cmp_load_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_cmp_load_cycle", cyc - t0, e.cyc);
                chk("a_cmp_vy", int'(vy_a), e.vy);
            end
        end
        if (cload_b === 1'b1) begin
            if (qb.size() == 0) chk("b_cmp_load_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_cmp_load_cycle", cyc - t0, e.cyc);
                chk("b_cmp_vy", int'(vy_b), e.vy);
            end
        end
        if (cclr_a === 1'b1) clr_a++;
        if (cclr_b === 1'b1) clr_b++;
        if (pc_a === 1'b1) begin
            pcn_a++;
            if (((cyc - t0 - 1) % 256) != 0) pc_bad++;
        end
        if (pc_b === 1'b1) pcn_b++;
        if (pv_a === 1'b1 && pvf_a < 0) pvf_a = cyc - t0;
        if (pv_b === 1'b1 && pvf_b < 0) pvf_b = cyc - t0;
        if (comp_a === 1'b1 && prev_a !== 1'b1) rise_a = cyc - t0;
        if (comp_b === 1'b1 && prev_b !== 1'b1) rise_b = cyc - t0;
        prev_a = comp_a;
        prev_b = comp_b;
    endtask

    task automatic begin_run();
        exp_t e;
        tick();
        t0 = cyc;
        clr_a = 0; clr_b = 0; pcn_a = 0; pcn_b = 0; pc_bad = 0;
        pvf_a = -1; pvf_b = -1; rise_a = -1; rise_b = -1;
        if (cclr_a) clr_a++;
        if (cclr_b) clr_b++;
        qa.delete();
        qb.delete();
        for (int n = 0; n < 16; n++) begin
            e.vy = n;
            e.cyc = 256*n + 255 + 2; qa.push_back(e);
            e.cyc = 256*n + 255 + 5; qb.push_back(e);
        end
    endtask

    task automatic finish_run();
        int guard = 0;
        while (!(comp_a && comp_b) && guard < 5000) begin
            tick();
            guard++;
        end
        chk("done_timeout", int'(comp_a && comp_b), 1);
        chk("a_completed_rise", rise_a, 4098);
        chk("b_completed_rise", rise_b, 4101);
        chk("a_pe_valid_first", pvf_a, 1);
        chk("b_pe_valid_first", pvf_b, 2);
        chk("a_cmp_clear_count", clr_a, 1);
        chk("b_cmp_clear_count", clr_b, 1);
        chk("a_pe_clear_count", pcn_a, 16);
        chk("b_pe_clear_count", pcn_b, 16);
        chk("a_pe_clear_placement", pc_bad, 0);
        chk("a_cmp_load_missing", qa.size(), 0);
        chk("b_cmp_load_missing", qb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs_a"}, int'({comp_a, busy_a, pv_a, pc_a, cclr_a, cload_a}), 0);
        chk({tag, "_addr_a"}, int'(r_a) + int'(s1_a) + int'(s2_a) + int'(sel_a) + int'(vy_a), 0);
        chk({tag, "_outs_b"}, int'({comp_b, busy_b, pv_b, pc_b, cclr_b, cload_b}), 0);
        chk({tag, "_addr_b"}, int'(r_b) + int'(s1_b) + int'(s2_b) + int'(sel_b) + int'(vy_b), 0);
    endtask

    initial begin
        int bad;
        //        off   R    S1   S2   pv pc sel        bsy cmp clr ld vy
        tab[0]  = '{0,    0,   0,  15, 0, 0, 16'h0000, 1, 0, 1, 0, 0};
        tab[1]  = '{1,    1,   1,  16, 1, 1, 16'hFFFE, 1, 0, 0, 0, 0};
        tab[2]  = '{4,    4,   4,  19, 1, 0, 16'hFFF0, 1, 0, 0, 0, 0};
        tab[3]  = '{16,  16,  31,  46, 1, 0, 16'h0000, 1, 0, 0, 0, 0};
        tab[4]  = '{17,  17,  32,  47, 1, 0, 16'hFFFE, 1, 0, 0, 0, 0};
        tab[5]  = '{256,  0,  31,  46, 1, 0, 16'h0000, 1, 0, 0, 0, 0};
        tab[6]  = '{257,  1,  32,  47, 1, 1, 16'hFFFE, 1, 0, 0, 1, 0};
        tab[7]  = '{3841, 1, 466, 481, 1, 1, 16'hFFFE, 1, 0, 0, 1, 14};
        tab[8]  = '{4095, 255, 945, 960, 1, 0, 16'h8000, 1, 0, 0, 0, 0};
        tab[9]  = '{4096, 0,   0,   0, 1, 0, 16'h0000, 1, 0, 0, 0, 0};
        tab[10] = '{4097, 0,   0,   0, 0, 0, 16'h0000, 1, 0, 0, 1, 15};
        tab[11] = '{4098, 0,   0,   0, 0, 0, 16'h0000, 0, 1, 0, 0, 0};

        tick();
        tick();
        chk_all_zero("reset");

        reset = 1'b0;
        start = 1'b1;
        begin_run();
        foreach (tab[n]) begin
            while (cyc - t0 < tab[n].off) tick();
            chk($sformatf("r_off%0d", tab[n].off), int'(r_a), int'(tab[n].r));
            chk($sformatf("s1_off%0d", tab[n].off), int'(s1_a), int'(tab[n].s1));
            chk($sformatf("s2_off%0d", tab[n].off), int'(s2_a), int'(tab[n].s2));
            chk($sformatf("pe_valid_off%0d", tab[n].off), int'(pv_a), int'(tab[n].pv));
            chk($sformatf("pe_clear_off%0d", tab[n].off), int'(pc_a), int'(tab[n].pc));
            chk($sformatf("pe_sel_off%0d", tab[n].off), int'(sel_a), int'(tab[n].sel));
            chk($sformatf("busy_off%0d", tab[n].off), int'(busy_a), int'(tab[n].busy));
            chk($sformatf("completed_off%0d", tab[n].off), int'(comp_a), int'(tab[n].comp));
            chk($sformatf("cmp_clear_off%0d", tab[n].off), int'(cclr_a), int'(tab[n].cclr));
            if (tab[n].cload) chk($sformatf("cmp_vy_off%0d", tab[n].off), int'(vy_a), int'(tab[n].vy));
        end
        finish_run();

        // Holding start in DONE must not retrigger.
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (!comp_a || !comp_b || busy_a || busy_b || pv_a || cclr_a || cclr_b || r_a != 0 || s1_a != 0 || r_b != 0)
                bad++;
        end
        chk("done_hold_bad_cycles", bad, 0);

        start = 1'b0;
        tick();
        chk("a_completed_after_drop", int'(comp_a), 0);
        chk("b_completed_after_drop", int'(comp_b), 0);

        // Rerun, then abort with reset mid-search.
        start = 1'b1;
        begin_run();
        chk("rerun_cmp_clear", int'(cclr_a), 1);
        while (cyc - t0 < 1000) tick();
        chk("rerun_loads_before_abort_a", qa.size(), 13);
        chk("rerun_loads_before_abort_b", qb.size(), 13);
        reset = 1'b1;
        qa.delete();
        qb.delete();
        tick();
        chk_all_zero("abort");
        for (int n = 0; n < 8; n++) tick();
        chk_all_zero("abort_hold");

        reset = 1'b0;
        begin_run();
        chk("restart_cmp_clear", int'(cclr_a), 1);
        chk("restart_r0", int'(r_a), 0);
        while (cyc - t0 < 16) tick();
        chk("restart_s1_off16", int'(s1_a), 31);
        chk("restart_b_s2_off16", int'(s2_b), 46);
        finish_run();

        start = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        chk("final_idle_a", int'({comp_a, busy_a}), 0);
        chk("final_queue_a", qa.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
